// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions for the horizontal and vertical state machines.
//   vga_state_e : 2-bit phase encoding used by both machines
//   H_*/V_*_DEF : 640x480@60 timing constants
//   next_phase  : line/frame phase order
package vga_timing_pkg;

    typedef enum logic [1:0] {
        FRONT_PORCH  = 2'd0,
        SYNC_PULSE   = 2'd1,
        BACK_PORCH   = 2'd2,
        ACTIVE_VIDEO = 2'd3
    } vga_state_e;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FRONT_DEF  = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BACK_DEF   = 48;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF  = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;

    function automatic vga_state_e next_phase(input vga_state_e s);
        case (s)
            ACTIVE_VIDEO: next_phase = FRONT_PORCH;
            FRONT_PORCH:  next_phase = SYNC_PULSE;
            SYNC_PULSE:   next_phase = BACK_PORCH;
            default:      next_phase = ACTIVE_VIDEO;
        endcase
    endfunction

endpackage

// File: rtl/vga_phase_counter.sv
// Enable-gated phase counter with synchronous clear and terminal-count
// compare against a runtime last value (phase length - 1).
//   clk_i, rst_ni : clock, async active-low reset
//   en_i          : count enable
//   clr_i         : synchronous clear, wins over en_i
//   last_i        : last count value of the current phase
//   cnt_o         : current count
//   tc_o          : cnt_o == last_i
module vga_phase_counter #(
    parameter int CNT_W = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] last_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;

    assign tc_o  = (cnt_q == last_i);
    assign cnt_o = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            cnt_q <= '0;
        else if (clr_i)
            cnt_q <= '0;
        else if (en_i)
            cnt_q <= tc_o ? '0 : cnt_q + 1'b1;
    end

endmodule

// File: rtl/horizontal_timing_generator.sv
// VGA horizontal timing: phase state machine + pixel counter.
//   clk_i, rst_ni : clock, async active-low reset
//   pix_en_i      : pixel-rate clock enable
//   line_rst_i    : synchronous restart to ACTIVE_VIDEO pixel 0
//   hsync_o       : active-low sync, low only in SYNC_PULSE
//   h_active_o    : high in ACTIVE_VIDEO
//   pixel_x_o     : column during active video, 0 otherwise
//   line_end_o    : one-cycle pulse on the last pixel of a line
module horizontal_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FRONT  = H_FRONT_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int CNT_W    = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             pix_en_i,
    input  logic             line_rst_i,
    output logic             hsync_o,
    output logic             h_active_o,
    output logic [CNT_W-1:0] pixel_x_o,
    output logic             line_end_o
);

    // Last values rather than lengths so a phase of 2**CNT_W still fits.
    localparam logic [CNT_W-1:0] LAST_ACT = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] LAST_FP  = CNT_W'(H_FRONT  - 1);
    localparam logic [CNT_W-1:0] LAST_SP  = CNT_W'(H_SYNC   - 1);
    localparam logic [CNT_W-1:0] LAST_BP  = CNT_W'(H_BACK   - 1);

    vga_state_e       state_q, state_d;
    logic [CNT_W-1:0] phase_last;
    logic [CNT_W-1:0] cnt;
    logic             tc;

    always_comb begin
        phase_last = LAST_FP;
        case (state_q)
            ACTIVE_VIDEO: phase_last = LAST_ACT;
            FRONT_PORCH:  phase_last = LAST_FP;
            SYNC_PULSE:   phase_last = LAST_SP;
            BACK_PORCH:   phase_last = LAST_BP;
            default:      phase_last = LAST_FP;
        endcase
    end

    // The counter self-wraps to 0 on terminal count, so the phase change
    // below and the wrap happen on the same edge. line_rst_i clears it.
    vga_phase_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (pix_en_i),
        .clr_i  (line_rst_i),
        .last_i (phase_last),
        .cnt_o  (cnt),
        .tc_o   (tc)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            state_q <= FRONT_PORCH;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (line_rst_i)
            state_d = ACTIVE_VIDEO;
        else if (pix_en_i && tc)
            state_d = next_phase(state_q);
    end

    assign hsync_o    = (state_q != SYNC_PULSE);
    assign h_active_o = (state_q == ACTIVE_VIDEO);
    assign pixel_x_o  = h_active_o ? cnt : '0;
    // Suppressed by line_rst_i: the restart replaces this line boundary.
    assign line_end_o = (state_q == BACK_PORCH) && tc && pix_en_i && !line_rst_i;

endmodule

// File: tb/tb_horizontal_timing_generator.sv
module tb_horizontal_timing_generator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pix_en, line_rst;
    logic       hsync, act, le;
    logic [9:0] px;

    logic       s_pix_en, s_line_rst;
    logic       s_hsync, s_act, s_le;
    logic [2:0] s_px;

    int checks = 0;
    int errors = 0;
    int edges  = 0;

    always #5 clk = ~clk;

    horizontal_timing_generator dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .pix_en_i   (pix_en),
        .line_rst_i (line_rst),
        .hsync_o    (hsync),
        .h_active_o (act),
        .pixel_x_o  (px),
        .line_end_o (le)
    );

    horizontal_timing_generator #(
        .H_ACTIVE (4),
        .H_FRONT  (1),
        .H_SYNC   (1),
        .H_BACK   (1),
        .CNT_W    (3)
    ) dut_s (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .pix_en_i   (s_pix_en),
        .line_rst_i (s_line_rst),
        .hsync_o    (s_hsync),
        .h_active_o (s_act),
        .pixel_x_o  (s_px),
        .line_end_o (s_le)
    );

    typedef struct {
        int   n;
        logic hs;
        logic ac;
        int   x;
        logic le;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, actual, expected, edges);
        end
    endtask

    // Advance one clock edge, then drive the next inputs and settle before sampling.
    task automatic step(input logic en, input logic lr);
        @(posedge clk);
        #1;
        pix_en   = en;
        line_rst = lr;
        #1;
        edges++;
    endtask

    initial begin
        int cnt_hs, cnt_ac, cnt_le, le_a, le_b, ramp_err, frz_err, wid_err, n, pos;
        logic p_hs, p_ac, p_en, p_le;
        int   p_x;

        // Position p after release (pix_en=1 always): 0..15 FP, 16..111 SP,
        // 112..159 BP, 160..799 ACTIVE; line_end on p=159.
        vecs[0]  = '{n:0,   hs:1, ac:0, x:0,   le:0};
        vecs[1]  = '{n:15,  hs:1, ac:0, x:0,   le:0};
        vecs[2]  = '{n:16,  hs:0, ac:0, x:0,   le:0};
        vecs[3]  = '{n:111, hs:0, ac:0, x:0,   le:0};
        vecs[4]  = '{n:112, hs:1, ac:0, x:0,   le:0};
        vecs[5]  = '{n:159, hs:1, ac:0, x:0,   le:1};
        vecs[6]  = '{n:160, hs:1, ac:1, x:0,   le:0};
        vecs[7]  = '{n:161, hs:1, ac:1, x:1,   le:0};
        vecs[8]  = '{n:799, hs:1, ac:1, x:639, le:0};
        vecs[9]  = '{n:800, hs:1, ac:0, x:0,   le:0};
        vecs[10] = '{n:959, hs:1, ac:0, x:0,   le:1};
        vecs[11] = '{n:960, hs:1, ac:1, x:0,   le:0};

        rst_n = 1'b0; pix_en = 1'b1; line_rst = 1'b0;
        s_pix_en = 1'b1; s_line_rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_hsync", hsync, 1);
        chk("rst_active", act, 0);
        chk("rst_x", px, 0);
        chk("rst_line_end", le, 0);
        chk("rst_s_hsync", s_hsync, 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Table of checkpoints across the first 1.2 lines
        for (int i = 0; i < 12; i++) begin
            while (edges < vecs[i].n) step(1'b1, 1'b0);
            chk($sformatf("vec%0d_hsync", i), hsync, vecs[i].hs);
            chk($sformatf("vec%0d_active", i), act, vecs[i].ac);
            chk($sformatf("vec%0d_x", i), px, vecs[i].x);
            chk($sformatf("vec%0d_line_end", i), le, vecs[i].le);
        end

        // Two full lines from p=160: counts, ramp and line_end period
        cnt_hs = 0; cnt_ac = 0; cnt_le = 0; le_a = -1; le_b = -1; ramp_err = 0;
        for (int i = 0; i < 1600; i++) begin
            pos = (160 + i) % 800;
            if (!hsync) cnt_hs++;
            if (act) cnt_ac++;
            if (le) begin
                cnt_le++;
                if (le_a < 0) le_a = i; else le_b = i;
            end
            if (pos >= 160) begin
                if (!act || px != 10'(pos - 160)) ramp_err++;
            end else if (act || px != 0) ramp_err++;
            step(1'b1, 1'b0);
        end
        chk("full_hsync_low", cnt_hs, 192);
        chk("full_active", cnt_ac, 1280);
        chk("full_line_end_cnt", cnt_le, 2);
        chk("full_line_period", le_b - le_a, 800);
        chk("full_ramp_err", ramp_err, 0);

        // Enable 1-in-4: period x4, pulse 1 wide, outputs frozen on idle edges
        le_a = -1; le_b = -1; frz_err = 0; wid_err = 0;
        p_hs = hsync; p_ac = act; p_x = px; p_en = pix_en; p_le = 1'b0;
        for (int k = 0; k < 7000; k++) begin
            step((k % 4) == 0, 1'b0);
            if (!p_en && (hsync != p_hs || act != p_ac || px != p_x)) frz_err++;
            if (le && p_le) wid_err++;
            if (le) begin
                if (le_a < 0) le_a = k; else if (le_b < 0) le_b = k;
            end
            p_hs = hsync; p_ac = act; p_x = px; p_en = pix_en; p_le = le;
        end
        chk("div4_period", le_b - le_a, 3200);
        chk("div4_freeze_err", frz_err, 0);
        chk("div4_width_err", wid_err, 0);

        // line_rst during SYNC_PULSE counter 40
        n = 0;
        while (hsync && n < 4000) begin step(1'b1, 1'b0); n++; end
        chk("sync_found", int'(hsync), 0);
        repeat (40) step(1'b1, 1'b0);
        chk("sync40_hsync", hsync, 0);
        line_rst = 1'b1;
        #1;
        step(1'b1, 1'b0);
        chk("lrst_active", act, 1);
        chk("lrst_x", px, 0);
        chk("lrst_hsync", hsync, 1);
        n = 0;
        while (!le && n < 1000) begin step(1'b1, 1'b0); n++; end
        chk("lrst_to_line_end", n, 799);

        // line_rst coincident with BACK_PORCH terminal count
        chk("bp_last_line_end", le, 1);
        line_rst = 1'b1;
        #1;
        chk("bp_lrst_suppress", le, 0);
        step(1'b1, 1'b1);
        chk("bp_lrst_active", act, 1);
        chk("bp_lrst_x", px, 0);
        repeat (3) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        chk("park_active", act, 1);
        chk("park_x", px, 0);
        chk("park_line_end", le, 0);
        step(1'b1, 1'b0);
        chk("park_exit_x", px, 0);

        // Async reset at pixel 300
        repeat (300) step(1'b1, 1'b0);
        chk("mid_x300", px, 300);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_hsync", hsync, 1);
        chk("async_active", act, 0);
        chk("async_x", px, 0);
        chk("async_line_end", le, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pix_en = 1'b1;
        line_rst = 1'b0;
        #1;
        n = 0;
        while (!act && n < 2000) begin step(1'b1, 1'b0); n++; end
        chk("post_rst_blank", n, 160);

        // Minimal 7-cycle line on the small instance
        n = 0;
        while (s_act && n < 20) begin step(1'b1, 1'b0); n++; end
        n = 0;
        while (!s_act && n < 20) begin step(1'b1, 1'b0); n++; end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("small_x%0d", i), s_px, i);
            chk($sformatf("small_active%0d", i), s_act, 1);
            step(1'b1, 1'b0);
        end
        chk("small_active_end", s_act, 0);
        cnt_hs = 0; cnt_le = 0; le_a = -1; le_b = -1;
        for (int i = 0; i < 14; i++) begin
            if (i < 7 && !s_hsync) cnt_hs++;
            if (s_le) begin
                cnt_le++;
                if (le_a < 0) le_a = i; else le_b = i;
            end
            step(1'b1, 1'b0);
        end
        chk("small_hsync_low", cnt_hs, 1);
        chk("small_line_end_cnt", cnt_le, 2);
        chk("small_period", le_b - le_a, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/horizontal_timing_generator.md
Name: horizontal_timing_generator

Overview:
Generates the VGA horizontal timing for one scan line: pixel counter, four-phase horizontal state machine, active-low HSYNC, horizontal active-video flag and pixel X coordinate. Sits directly upstream of the vertical state machine. Its one-cycle line_end_o pulse advances the vertical counter. The vertical state machine's horizontal-reset output drives line_rst_i, so the first visible line starts pixel-aligned.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FRONT, 16, front-porch pixels
H_SYNC, 96, sync-pulse pixels
H_BACK, 48, back-porch pixels
CNT_W, 10, pixel counter / pixel_x_o width; must hold max(H_*)-1
All H_* are >=1; zero-length phases are illegal.

Ports:
clk_i  in  1  system clock, all logic on rising edge
rst_ni  in  1  asynchronous active-low reset
pix_en_i  in  1  pixel-rate clock enable (e.g. 1-in-4 at 100 MHz for 25 MHz)
line_rst_i  in  1  synchronous restart to start of active video (from vertical state machine)
hsync_o  out  1  horizontal sync, active-low
h_active_o  out  1  high while the current pixel is in the active region
pixel_x_o  out  CNT_W  pixel column 0..H_ACTIVE-1 during active, 0 otherwise
line_end_o  out  1  one clk_i-cycle pulse on the last pixel of a line

Behaviour:
- Reset: asynchronous, active-low, fixed as decided. While rst_ni=0: state=FRONT_PORCH, counter=0, hsync_o=1, h_active_o=0, pixel_x_o=0, line_end_o=0.
- States and line order: ACTIVE_VIDEO -> FRONT_PORCH -> SYNC_PULSE -> BACK_PORCH -> ACTIVE_VIDEO.
- Phase lengths, in pix_en_i cycles: H_ACTIVE, H_FRONT, H_SYNC, H_BACK. Line total = 800 at defaults.
- Counter:
  - Advances only on clk_i edges with pix_en_i=1.
  - Within a phase it runs 0..LEN-1.
  - At LEN-1 with pix_en_i=1: counter goes to 0 and state advances on the same edge.
  - With pix_en_i=0: state and counter hold.
- Moore outputs, decoded from the registered state/counter (no extra pipeline stage):
  - hsync_o=0 only in SYNC_PULSE, 1 elsewhere.
  - h_active_o=1 only in ACTIVE_VIDEO.
  - pixel_x_o = counter in ACTIVE_VIDEO, else 0.
- line_end_o (Mealy, combinational):
  - 1 when state=BACK_PORCH, counter=H_BACK-1, pix_en_i=1 and line_rst_i=0.
  - Exactly one clk_i cycle wide, once per line.
- line_rst_i:
  - Next edge forces state=ACTIVE_VIDEO and counter=0, independent of pix_en_i.
  - Overrides any terminal-count transition in the same cycle; line_end_o is suppressed that cycle.
  - Held high: stays parked at ACTIVE_VIDEO, counter 0.
- Reset mid-line: immediate return to the reset values above. After release, the first line starts at FRONT_PORCH, so the first ACTIVE_VIDEO comes after a full blanking interval.
- No wrap hazard: the counter never exceeds max(H_*)-1, so CNT_W=10 covers the defaults.

Decomposition:
- Shared package vga_timing_pkg:
  - 2-bit state encodings (FRONT_PORCH=0, SYNC_PULSE=1, BACK_PORCH=2, ACTIVE_VIDEO=3), identical to the vertical machine's.
  - 640x480@60 horizontal and vertical timing constants.
- One natural sub-module: vga_phase_counter. It is an enable-gated counter with synchronous clear and a terminal-count compare against a runtime length, and is reusable by the vertical path.

Test Plan:
1. Reset, then pix_en_i=1 every cycle, line_rst_i=0 -> line_end_o period exactly 800 clk_i; hsync_o low 96 consecutive cycles; h_active_o high 640; pixel_x_o ramps 0..639 then 0.
2. pix_en_i=1 one cycle in four -> all phase lengths scale by 4 (line_end_o period 3200 clk_i); line_end_o still 1 clk_i wide; outputs frozen when pix_en_i=0.
3. line_rst_i pulsed during SYNC_PULSE at counter=40 -> next cycle h_active_o=1, pixel_x_o=0, hsync_o=1; next line_end_o arrives 800 pix_en_i later.
4. line_rst_i asserted in the same cycle as BACK_PORCH counter=47 with pix_en_i=1 -> line_end_o stays 0; state=ACTIVE_VIDEO, counter=0.
5. rst_ni dropped asynchronously mid-ACTIVE_VIDEO at pixel 300 -> outputs go to reset values without waiting for a clock edge; after release, h_active_o first rises after 16+96+48=160 pix_en_i.
6. Parameters H_ACTIVE=4, H_FRONT=1, H_SYNC=1, H_BACK=1 -> 7-cycle line; hsync_o low exactly 1 cycle; pixel_x_o sequence 0,1,2,3.
